// File: rtl/rca_pipe_if.sv
// Operand/result bundle for rca_pipe: a valid-qualified operand set in,
// a valid-qualified sum, carry and overflow out.
interface rca_pipe_if #(
    parameter int unsigned W = 16
) ();
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic [W-1:0] s;
    logic         c;
    logic         v;

    modport master (
        output in_valid, a, b, cin, sub,
        input  out_valid, s, c, v
    );

    modport slave (
        input  in_valid, a, b, cin, sub,
        output out_valid, s, c, v
    );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry add/subtract: W bits split into STAGES chunks of W/STAGES bits,
// with the carry between chunks registered. W must be >= 2 and divisible by STAGES.
module rca_pipe #(
    parameter int unsigned W      = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic       clk,
    input  logic       rst,
    rca_pipe_if.slave  bus
);
    localparam int unsigned K    = W / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Register j feeds stage j. Operands ride along whole; stage j only consumes chunk j,
    // which gives chunk i its i-cycle skew, and finished sum chunks ride along as deskew.
    logic [STAGES-1:0] pv;
    logic [W-1:0]      pa [STAGES];
    logic [W-1:0]      pb [STAGES];
    logic [W-1:0]      ps [STAGES];
    logic              pc [STAGES];

    logic [W-1:0]      sum_nxt [STAGES];
    logic              co      [STAGES];

    logic              out_valid_q;
    logic [W-1:0]      s_q;
    logic              c_q;
    logic              v_q;

    always_comb begin
        for (int unsigned j = 0; j < STAGES; j++) begin
            sum_nxt[j] = ps[j];
            {co[j], sum_nxt[j][j*K +: K]} = {1'b0, pa[j][j*K +: K]}
                                          + {1'b0, pb[j][j*K +: K]}
                                          + {{K{1'b0}}, pc[j]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv          <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            for (int unsigned j = 0; j < STAGES; j++) begin
                pa[j] <= '0;
                pb[j] <= '0;
                ps[j] <= '0;
                pc[j] <= 1'b0;
            end
        end else begin
            // Subtract as a + ~b + ~cin, so cin acts as a borrow-in.
            pv[0] <= bus.in_valid;
            if (bus.in_valid) begin
                pa[0] <= bus.a;
                pb[0] <= bus.b ^ {W{bus.sub}};
                pc[0] <= bus.cin ^ bus.sub;
            end

            for (int unsigned j = 1; j < STAGES; j++) begin
                pv[j] <= pv[j-1];
                if (pv[j-1]) begin
                    pa[j] <= pa[j-1];
                    pb[j] <= pb[j-1];
                    ps[j] <= sum_nxt[j-1];
                    pc[j] <= co[j-1];
                end
            end

            out_valid_q <= pv[LAST];
            if (pv[LAST]) begin
                s_q <= sum_nxt[LAST];
                c_q <= co[LAST];
                // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
                v_q <= pa[LAST][W-1] ^ pb[LAST][W-1] ^ sum_nxt[LAST][W-1] ^ co[LAST];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: three instances (STAGES 4, 1, 16) share directed stimulus; each has
// a queue of hand-computed results with their due edge, popped by a negedge monitor.
module tb_rca_pipe;
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        drv_valid;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic        drv_cin;
    logic        drv_sub;

    int          edge_n = 0;
    logic        rst_seen = 1'b0;
    logic        started = 1'b0;
    int          checks = 0;
    int          passes = 0;
    int          stg [3] = '{4, 1, 16};

    exp_t        q [3][$];
    logic [15:0] last_s [3];
    logic        last_c [3];
    logic        last_v [3];

    rca_pipe_if #(.W(16)) if4 ();
    rca_pipe_if #(.W(16)) if1 ();
    rca_pipe_if #(.W(16)) if16 ();

    assign if4.in_valid  = drv_valid;
    assign if4.a         = drv_a;
    assign if4.b         = drv_b;
    assign if4.cin       = drv_cin;
    assign if4.sub       = drv_sub;
    assign if1.in_valid  = drv_valid;
    assign if1.a         = drv_a;
    assign if1.b         = drv_b;
    assign if1.cin       = drv_cin;
    assign if1.sub       = drv_sub;
    assign if16.in_valid = drv_valid;
    assign if16.a        = drv_a;
    assign if16.b        = drv_b;
    assign if16.cin      = drv_cin;
    assign if16.sub      = drv_sub;

    rca_pipe #(.W(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    rca_pipe #(.W(16), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    rca_pipe #(.W(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s (STAGES=%0d) at edge %0d: got %h, want %h",
                      name, stg[k], edge_n, act, exp);
    endtask

    task automatic check_dut(input int k, input logic ov, input logic [15:0] s,
                             input logic c, input logic v);
        logic exp_ov;
        if (rst_seen) begin
            q[k].delete();
            last_s[k] = '0;
            last_c[k] = 1'b0;
            last_v[k] = 1'b0;
        end
        exp_ov = (q[k].size() > 0) && (q[k][0].due == edge_n);
        chk("out_valid", k, {31'd0, ov}, {31'd0, exp_ov});
        if (exp_ov) begin
            last_s[k] = q[k][0].s;
            last_c[k] = q[k][0].c;
            last_v[k] = q[k][0].v;
            void'(q[k].pop_front());
        end
        // Outside a valid cycle the outputs must hold the previous result.
        chk("s", k, {16'd0, s}, {16'd0, last_s[k]});
        chk("c", k, {31'd0, c}, {31'd0, last_c[k]});
        chk("v", k, {31'd0, v}, {31'd0, last_v[k]});
    endtask

    always @(negedge clk) begin
        if (rst_seen) started = 1'b1;
        if (started) begin
            check_dut(0, if4.out_valid, if4.s, if4.c, if4.v);
            check_dut(1, if1.out_valid, if1.s, if1.c, if1.v);
            check_dut(2, if16.out_valid, if16.s, if16.c, if16.v);
        end
    end

    task automatic issue(input logic [15:0] a_, input logic [15:0] b_, input logic cin_,
                         input logic sub_, input logic [15:0] es, input logic ec,
                         input logic ev);
        exp_t e;
        @(negedge clk);
        #1;
        rst       = 1'b0;
        drv_valid = 1'b1;
        drv_a     = a_;
        drv_b     = b_;
        drv_cin   = cin_;
        drv_sub   = sub_;
        for (int k = 0; k < 3; k++) begin
            e.s   = es;
            e.c   = ec;
            e.v   = ev;
            e.due = edge_n + 1 + stg[k];
            q[k].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            rst       = 1'b0;
            drv_valid = 1'b0;
            drv_a     = 16'($urandom);
            drv_b     = 16'($urandom);
            drv_cin   = 1'($urandom);
            drv_sub   = 1'($urandom);
        end
    endtask

    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            rst       = 1'b1;
            drv_valid = 1'b1;
            drv_a     = 16'h1234;
            drv_b     = 16'h4321;
            drv_cin   = 1'b1;
            drv_sub   = 1'b0;
        end
    endtask

    task automatic streaming();
        issue(16'h000A, 16'h000C, 1'b0, 1'b0, 16'h0016, 1'b0, 1'b0);
        issue(16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
        issue(16'h0005, 16'h000B, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 edges with in_valid high; those inputs must be dropped.
        rst       = 1'b1;
        drv_valid = 1'b1;
        drv_a     = 16'h1234;
        drv_b     = 16'h4321;
        drv_cin   = 1'b1;
        drv_sub   = 1'b0;
        repeat (2) @(negedge clk);
        reset_cycles(1);
        idle(6);

        // Cross-chunk carry, overflow and subtract.
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        issue(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        idle(20);

        streaming();
        idle(20);

        // Bubble: valid, invalid, valid.
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        idle(1);
        issue(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
        idle(20);

        // Two operations in flight, then a one-cycle reset.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        issue(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        reset_cycles(1);
        idle(20);

        streaming();
        idle(24);

        for (int k = 0; k < 3; k++) chk("drain", k, 32'(q[k].size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/rca_pipe.md
# rca_pipe

Parametrised, pipelined successor to the team's 4-bit ripple-carry adder. Computes a W-bit add or subtract by splitting the operands into STAGES equal ripple-carry segments, with the inter-segment carry registered so each cycle only ripples W/STAGES bits. A valid strobe travels with each operand set, so a new operation can enter every cycle and results emerge in order. It sits in the datapath wherever a wide adder would otherwise limit clock frequency.

## Interface
- W, default 16: operand and sum width in bits. Must be ≥ 2.
- STAGES, default 4: number of pipeline segments. Must divide W exactly; chunk width K = W/STAGES.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies a, b, cin and sub this cycle.
- a  in  W  operand A, unsigned or two's complement.
- b  in  W  operand B.
- cin  in  1  carry-in when sub=0; borrow-in when sub=1.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  s, c and v carry a new result this cycle.
- s  out  W  sum or difference.
- c  out  1  raw carry out of the MSB; when sub=1, c=1 means no borrow.
- v  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operation: sub=0 gives s = a + b + cin. sub=1 gives s = a + ~b + ~cin, which is a − b − cin mod 2^W. c is bit W of that internal sum.
- Stage i (0..STAGES−1) adds chunk i, bits [iK+K−1 : iK], of a and of the effective b. Its carry-in is the effective cin for stage 0, and the registered carry from stage i−1 otherwise.
- Skew registers delay operand chunk i by i cycles so it meets its incoming carry.
- Deskew registers delay sum chunk i by STAGES−1−i cycles so all W sum bits leave aligned.
- Each stage keeps a valid bit, shifted forward every cycle. Stage data registers capture only when that stage's incoming valid is 1; otherwise they hold.
- Output registers s, c and v load only when a valid result leaves the last stage. They hold their last value while out_valid=0.
- v is computed in the last stage from the carry into bit W−1 and the carry out of bit W−1.
- There is no backpressure. The downstream consumer must accept every out_valid cycle.
- STAGES=1 gives a plain registered ripple-carry adder.

## Timing
- Latency: an input accepted at edge n, with in_valid=1, appears at edge n+STAGES, with out_valid=1 for exactly one cycle.
- Throughput: one operation per cycle. Back-to-back inputs give back-to-back outputs, in order.
- Bubbles: each in_valid=0 cycle produces exactly one out_valid=0 cycle, STAGES cycles later. During that cycle s, c and v hold.
- Reset: at an edge with rst=1, all valid bits, skew and deskew registers, carries and outputs clear to 0. After that edge s=0, c=0, v=0, out_valid=0.
- Reset has priority over in_valid in the same cycle. That input is dropped.
- Reset mid-operation: all in-flight operations are discarded, and no out_valid is produced for them.
- After rst falls, the first out_valid comes exactly STAGES cycles after the first accepted input.
- Wrap-around: results are mod 2^W, with overflow reported only through c and v.
- Mixed operations: add and subtract may alternate every cycle. sub travels with its operand set.

## Test plan
- Reset: hold rst 3 cycles while driving in_valid=1 -> s=0x0000, c=0, v=0, out_valid=0 throughout; no out_valid within 4 cycles after release.
- Cross-chunk carry (W=16, STAGES=4): a=0x00FF, b=0x0001, cin=0, sub=0 -> after 4 cycles s=0x0100, c=0, v=0. Then a=0xFFFF, b=0x0001, cin=1 -> s=0x0001, c=1, v=0.
- Overflow and subtract: a=0x7FFF + b=0x0001 -> s=0x8000, v=1, c=0. Then a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, c=0, v=0. Then a=0x0007, b=0x0005, sub=1, cin=1 -> s=0x0001, c=1.
- Streaming: 4 consecutive valid inputs (0x000A+0x000C, 0x000F+0x0001, 0x0005+0x000B, 0xFFFF+0xFFFF) -> outputs on 4 consecutive cycles: 0x0016, 0x0010, 0x0010, 0xFFFE with c=1.
- Bubble hold: pattern valid, invalid, valid -> out_valid pattern 1,0,1. During the 0 cycle s holds the first result.
- Reset mid-flight: 2 operations in flight, assert rst 1 cycle -> neither produces out_valid; outputs are 0. Rerun the streaming case with STAGES=1 and STAGES=16 -> same values at latency 1 and 16.
